// File: rtl/mult_ctrl_8x8.sv
// Control unit and X/A/B/S registers for the signed shift-add multiplier; the adder is external.
// Optional build macro MULT_ADD_SKIP_EN: skip the ADD state when the multiplier bit is 0.
module mult_ctrl_8x8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH:0]   add_a,
    output logic [WIDTH:0]   add_sw,
    output logic             add_fn,
    input  logic [WIDTH:0]   add_s,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;

    state_e           state_q;
    logic             x_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic [CW-1:0]    count_q;
    logic             done_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ClearA_LoadB) begin
                        x_q <= 1'b0;
                        a_q <= '0;
                        b_q <= SW;
                    end else if (Run) begin
                        x_q     <= 1'b0;
                        a_q     <= '0;
                        s_q     <= SW;
                        count_q <= '0;
`ifdef MULT_ADD_SKIP_EN
                        state_q <= b_q[0] ? StAdd : StShift;
`else
                        state_q <= StAdd;
`endif
                    end
                end
                StAdd: begin
                    if (b_q[0]) {x_q, a_q} <= add_s;
                    state_q <= StShift;
                end
                StShift: begin
                    // Arithmetic right shift of X:A:B; X keeps the sign.
                    a_q     <= {x_q, a_q[WIDTH-1:1]};
                    b_q     <= {a_q[0], b_q[WIDTH-1:1]};
                    count_q <= count_q + CW'(1);
                    if (count_q == LastCount) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
`ifdef MULT_ADD_SKIP_EN
                    // b_q[1] becomes the next multiplier bit after this shift.
                    else if (!b_q[1]) state_q <= StShift;
`endif
                    else state_q <= StAdd;
                end
                StDone: begin
                    if (!Run) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Last partial product carries the negative weight of the multiplier sign bit.
    assign add_fn = (state_q == StAdd) && (count_q == LastCount);
    assign add_a  = {a_q[WIDTH-1], a_q};
    assign add_sw = {s_q[WIDTH-1], s_q};
    assign Aval   = a_q;
    assign Bval   = b_q;
    assign Xval   = x_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mult_ctrl_8x8.sv
// Directed bench for mult_ctrl_8x8 with a behavioural model of the external 9-bit adder.
module tb_mult_ctrl_8x8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       ClearA_LoadB = 1'b0;
    logic [7:0] SW = 8'h00;
    logic [8:0] add_a;
    logic [8:0] add_sw;
    logic       add_fn;
    logic [8:0] add_s;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    assign add_s = add_a + (add_sw ^ {9{add_fn}}) + {8'b0, add_fn};

    mult_ctrl_8x8 #(.WIDTH(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .ClearA_LoadB(ClearA_LoadB),
        .SW          (SW),
        .add_a       (add_a),
        .add_sw      (add_sw),
        .add_fn      (add_fn),
        .add_s       (add_s),
        .Aval        (Aval),
        .Bval        (Bval),
        .Xval        (Xval),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input string tag, input logic [7:0] b);
        SW = b;
        ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0;
        check({tag, " load B"}, {24'b0, Bval}, {24'b0, b});
        check({tag, " load A"}, {24'b0, Aval}, 32'h0);
    endtask

    // b is B at start, used only for the expected latency.
    task automatic do_mult(input string tag, input logic [7:0] b, input logic [7:0] s,
                           input logic [15:0] prod, input logic xe);
        int lat;
        int lat_exp;
`ifdef MULT_ADD_SKIP_EN
        lat_exp = 8 + $countones(b);
`else
        lat_exp = 16;
`endif
        SW  = s;
        Run = 1'b1;
        tick();  // edge 0
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 3) begin
                SW = 8'hA5;
                ClearA_LoadB = 1'b1;
            end else begin
                ClearA_LoadB = 1'b0;
            end
            tick();
            lat++;
        end
        ClearA_LoadB = 1'b0;
        check({tag, " latency"}, lat, lat_exp);
        check({tag, " product"}, {16'b0, Aval, Bval}, {16'b0, prod});
        check({tag, " X"}, {31'b0, Xval}, {31'b0, xe});
        check({tag, " done"}, {31'b0, done}, 32'h1);
        tick();
        check({tag, " done held"}, {31'b0, done}, 32'h1);
        Run = 1'b0;
        tick();
        check({tag, " idle"}, {31'b0, done}, 32'h0);
    endtask

    initial begin
        tick();
        Reset = 1'b0;
        check("rst A", {24'b0, Aval}, 32'h0);
        check("rst B", {24'b0, Bval}, 32'h0);
        check("rst X", {31'b0, Xval}, 32'h0);
        check("rst done", {31'b0, done}, 32'h0);
        check("rst fn", {31'b0, add_fn}, 32'h0);

        load_b("t1", 8'h07);
        do_mult("t1", 8'h07, 8'h3B, 16'h019D, 1'b0);
        // No reload: previous low byte 0x9D (-99) times 2.
        do_mult("t2", 8'h9D, 8'h02, 16'hFF3A, 1'b1);

        load_b("t3", 8'hF9);
        do_mult("t3", 8'hF9, 8'h3B, 16'hFE63, 1'b1);

        load_b("t4", 8'h80);
        do_mult("t4", 8'h80, 8'h80, 16'h4000, 1'b0);

        // Reset at edge 5 of a run with Run low.
        load_b("t5", 8'h07);
        SW  = 8'h3B;
        Run = 1'b1;
        tick();  // edge 0
        Run = 1'b0;
        repeat (4) tick();
        Reset = 1'b1;
        tick();  // edge 5
        Reset = 1'b0;
        check("t5 rst A", {24'b0, Aval}, 32'h0);
        check("t5 rst B", {24'b0, Bval}, 32'h0);
        check("t5 rst X", {31'b0, Xval}, 32'h0);
        check("t5 rst done", {31'b0, done}, 32'h0);
        repeat (3) tick();
        check("t5 stays idle A", {24'b0, Aval}, 32'h0);
        check("t5 stays idle done", {31'b0, done}, 32'h0);
        load_b("t5b", 8'h07);
        do_mult("t5b", 8'h07, 8'h3B, 16'h019D, 1'b0);

        load_b("t6", 8'h01);
        do_mult("t6", 8'h01, 8'h05, 16'h0005, 1'b0);

        load_b("t7", 8'h7F);
        do_mult("t7", 8'h7F, 8'h7F, 16'h3F01, 1'b0);

        load_b("t8", 8'hFF);
        do_mult("t8", 8'hFF, 8'h01, 16'hFFFF, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
